// File: rtl/spi_ram_ctrl_if.sv
// spi_ram_ctrl_if
// ----------------
// Purpose: bundles the frame/response signals between the SPI slave and
//          the command controller (spi_ram_ctrl).
// Signals:
//   din      [9:0]  frame from the SPI slave: [9:8] command, [7:0] payload
//   rx_valid        frame-valid level; may remain high for many cycles
//   dout     [7:0]  read byte handed back to the SPI slave
//   tx_valid        dout holds a valid read byte
//   seq_err         one-cycle pulse on an illegal command sequence
//   busy            a read response is outstanding (mirrors tx_valid)
// Modports:
//   master - the SPI slave side (drives frames, consumes responses)
//   slave  - the controller side (consumes frames, drives responses)
interface spi_ram_ctrl_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       seq_err;
  logic       busy;

  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid,
    input  seq_err,
    input  busy
  );

  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid,
    output seq_err,
    output busy
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl
// ------------
// Purpose: command controller and backing store behind an SPI slave.
//          Each rising edge of rx_valid delivers one 10-bit frame that is
//          decoded as write-address (00), write-data (01), read-address (10)
//          or read-data (11). Write data goes into an internal RAM, read
//          data is returned on dout/tx_valid with one cycle of latency.
// Parameters:
//   MEM_DEPTH  number of 8-bit RAM words, equal to 2**ADDR_SIZE
//   ADDR_SIZE  address width (1..8); upper payload bits are ignored
//   AUTO_INC   1 = address post-increments after each data access
// Ports:
//   clk    rising-edge system clock
//   rst_n  synchronous active-low reset (RAM contents are kept)
//   bus    slave modport of spi_ram_ctrl_if (din, rx_valid, dout,
//          tx_valid, seq_err, busy)
module spi_ram_ctrl #(
  parameter int unsigned MEM_DEPTH = 32'd256,
  parameter int unsigned ADDR_SIZE = 32'd8,
  parameter int unsigned AUTO_INC  = 32'd1
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WR_READY = 2'b01,
    RD_READY = 2'b10,
    RD_RESP  = 2'b11
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Backing store; deliberately not reset so contents survive rst_n.
  logic [7:0] ram_mem [MEM_DEPTH];

  state_t                 state_q,       state_d;
  logic [ADDR_SIZE-1:0]   wr_addr_q,     wr_addr_d;
  logic [ADDR_SIZE-1:0]   rd_addr_q,     rd_addr_d;
  logic                   wr_addr_vld_q, wr_addr_vld_d;
  logic                   rd_addr_vld_q, rd_addr_vld_d;
  logic                   rx_prev_q,     rx_prev_d;
  logic [7:0]             dout_q,        dout_d;
  logic                   tx_valid_q,    tx_valid_d;
  logic                   seq_err_q,     seq_err_d;

  logic                   accept_s;
  logic [1:0]             cmd_s;
  logic                   mem_we_s;

  // One command per rx_valid rising edge, however long the level is held.
  assign accept_s = bus.rx_valid & ~rx_prev_q;
  assign cmd_s    = bus.din[9:8];

  // Command decode, address sequencing and response generation.
  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_vld_d = wr_addr_vld_q;
    rd_addr_vld_d = rd_addr_vld_q;
    rx_prev_d     = bus.rx_valid;
    dout_d        = dout_q;
    tx_valid_d    = tx_valid_q;
    seq_err_d     = 1'b0;
    mem_we_s      = 1'b0;

    if (accept_s) begin
      // Any accepted frame retires the outstanding response; a legal
      // read-data below re-asserts it with the new byte.
      tx_valid_d = 1'b0;
      case (cmd_s)
        CMD_WR_ADDR: begin
          wr_addr_d     = bus.din[ADDR_SIZE-1:0];
          wr_addr_vld_d = 1'b1;
          state_d       = WR_READY;
        end
        CMD_WR_DATA: begin
          if (wr_addr_vld_q) begin
            mem_we_s = 1'b1;
            state_d  = WR_READY;
            if (AUTO_INC != 32'd0) begin
              // Power-of-two depth: natural overflow gives the wrap to 0.
              wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
            end else begin
              wr_addr_d = wr_addr_q;
            end
          end else begin
            seq_err_d = 1'b1;
            state_d   = rd_addr_vld_q ? RD_READY : IDLE;
          end
        end
        CMD_RD_ADDR: begin
          rd_addr_d     = bus.din[ADDR_SIZE-1:0];
          rd_addr_vld_d = 1'b1;
          state_d       = RD_READY;
        end
        CMD_RD_DATA: begin
          if (rd_addr_vld_q) begin
            dout_d     = ram_mem[rd_addr_q];
            tx_valid_d = 1'b1;
            state_d    = RD_RESP;
            if (AUTO_INC != 32'd0) begin
              rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
            end else begin
              rd_addr_d = rd_addr_q;
            end
          end else begin
            // Illegal read leaves dout untouched; only tx_valid drops
            // because a frame was accepted.
            seq_err_d = 1'b1;
            state_d   = wr_addr_vld_q ? WR_READY : IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      wr_addr_vld_q <= 1'b0;
      rd_addr_vld_q <= 1'b0;
      rx_prev_q     <= 1'b0;
      dout_q        <= 8'h00;
      tx_valid_q    <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_vld_q <= wr_addr_vld_d;
      rd_addr_vld_q <= rd_addr_vld_d;
      rx_prev_q     <= rx_prev_d;
      dout_q        <= dout_d;
      tx_valid_q    <= tx_valid_d;
      seq_err_q     <= seq_err_d;
    end
  end

  // RAM write port; reset wins over a frame accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_s) begin
      ram_mem[wr_addr_q] <= bus.din[7:0];
    end
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.seq_err  = seq_err_q;
  assign bus.busy     = tx_valid_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl
// ---------------
// Directed self-checking bench for spi_ram_ctrl (default parameters).
// Frames are driven on the falling edge, accepted on the following rising
// edge, and outputs are sampled on the next falling edge (cycle T+1).
module tb_spi_ram_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks_r = 0;
  int   errors_r = 0;

  spi_ram_ctrl_if bus_if ();

  spi_ram_ctrl #(
    .MEM_DEPTH (256),
    .ADDR_SIZE (8),
    .AUTO_INC  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [15:0] obs,
                           input logic [15:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One frame: rx_valid high for exactly one cycle; returns at T+1 sample point.
  task automatic send(input logic [9:0] frame);
    @(negedge clk);
    bus_if.din      = frame;
    bus_if.rx_valid = 1'b1;
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.din      = 10'h000;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    bus_if.din      = 10'h000;
    bus_if.rx_valid = 1'b0;

    // ---------------- reset values
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    check_val("rst_dout",     bus_if.dout,     16'h00);
    check_val("rst_tx_valid", bus_if.tx_valid, 16'h0);
    check_val("rst_seq_err",  bus_if.seq_err,  16'h0);
    check_val("rst_busy",     bus_if.busy,     16'h0);
    rst_n = 1'b1;

    // ---------------- test 1: basic write then read
    send(10'h005);
    send(10'h1A5);
    check_val("t1_wr_seq_err", bus_if.seq_err, 16'h0);
    send(10'h205);
    send(10'h300);
    check_val("t1_dout",     bus_if.dout,     16'hA5);
    check_val("t1_tx_valid", bus_if.tx_valid, 16'h1);
    check_val("t1_busy",     bus_if.busy,     16'h1);
    check_val("t1_seq_err",  bus_if.seq_err,  16'h0);
    idle(3);
    check_val("t1_hold_dout",  bus_if.dout,     16'hA5);
    check_val("t1_hold_valid", bus_if.tx_valid, 16'h1);

    // ---------------- test 2: auto-increment with wrap
    send(10'h0FF);
    check_val("t2_txv_drop", bus_if.tx_valid, 16'h0);
    check_val("t2_busy_drop", bus_if.busy,    16'h0);
    send(10'h111);
    send(10'h122);
    send(10'h2FF);
    send(10'h300);
    check_val("t2_rd_ff",      bus_if.dout,     16'h11);
    check_val("t2_rd_ff_txv",  bus_if.tx_valid, 16'h1);
    send(10'h300);
    check_val("t2_rd_wrap",     bus_if.dout,     16'h22);
    check_val("t2_rd_wrap_txv", bus_if.tx_valid, 16'h1);

    // ---------------- test 3: long rx_valid yields a single write
    send(10'h004);
    send(10'h144);
    send(10'h003);
    @(negedge clk);
    bus_if.din      = 10'h1C3;
    bus_if.rx_valid = 1'b1;
    idle(12);
    bus_if.rx_valid = 1'b0;
    send(10'h203);
    send(10'h300);
    check_val("t3_ram3", bus_if.dout, 16'hC3);
    send(10'h300);
    check_val("t3_ram4", bus_if.dout, 16'h44);

    // ---------------- test 4: data commands without an address
    do_reset();
    send(10'h155);
    check_val("t4_wr_seq_err", bus_if.seq_err,  16'h1);
    check_val("t4_wr_txv",     bus_if.tx_valid, 16'h0);
    idle(1);
    check_val("t4_seq_err_pulse", bus_if.seq_err, 16'h0);
    send(10'h300);
    check_val("t4_rd_seq_err", bus_if.seq_err,  16'h1);
    check_val("t4_rd_txv",     bus_if.tx_valid, 16'h0);
    check_val("t4_rd_dout",    bus_if.dout,     16'h00);
    send(10'h200);
    send(10'h300);
    check_val("t4_no_write", bus_if.dout, 16'h22);

    // ---------------- test 5: reset during a response
    send(10'h205);
    send(10'h300);
    check_val("t5_pre_dout", bus_if.dout, 16'hA5);
    @(negedge clk);
    rst_n           = 1'b0;
    bus_if.din      = 10'h00A;   // accepted concurrently with reset: discarded
    bus_if.rx_valid = 1'b1;
    @(negedge clk);
    check_val("t5_rst_dout", bus_if.dout,     16'h00);
    check_val("t5_rst_txv",  bus_if.tx_valid, 16'h0);
    check_val("t5_rst_busy", bus_if.busy,     16'h0);
    bus_if.rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(10'h155);
    check_val("t5_discard_seq_err", bus_if.seq_err, 16'h1);
    send(10'h300);
    check_val("t5_rd_seq_err", bus_if.seq_err,  16'h1);
    check_val("t5_rd_txv",     bus_if.tx_valid, 16'h0);
    send(10'h205);
    send(10'h300);
    check_val("t5_ram_kept", bus_if.dout,     16'hA5);
    check_val("t5_txv",      bus_if.tx_valid, 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
